bmc_soft_pipe: RTL
==================

// Module: bmc_soft_pipe
// PURPOSE
// - Parametrised branch-metric unit for the rate-1/2, K=3 Viterbi decoder.
// - Per accepted received pair, computes all four branch metrics in parallel, one for
//   each expected code symbol 00/01/10/11. Supports soft-decision input, per-bit
//   erasure (puncturing) and a frame-last marker.
// - One registered valid/ready stage; sits between the demapper/depuncturer and the ACS array.
// - SW=1 with no erasures reproduces the hard-decision Hamming metrics of the bmcN cells.
// PARAMETERS
// - SW     3   soft bits per received code bit, unsigned; 0 = strong '0', 2**SW-1 = strong '1'.
// - CNT_W  16  width of the accepted-pair index counter.
// - MW     --  localparam = SW+1, the width of each branch metric.
// PORTS
// - clk           in   1        rising-edge clock
// - rst_n         in   1        synchronous, active-low reset
// - in_valid      in   1        rx pair valid
// - in_ready      out  1        unit can accept a pair this cycle
// - rx_pair       in   2*SW     [2*SW-1:SW] = code bit 1 (c1), [SW-1:0] = code bit 0 (c0)
// - rx_erase      in   2        [1] erases c1, [0] erases c0 (punctured bit)
// - in_last       in   1        pair is the last of a frame
// - out_valid     out  1        metrics valid
// - out_ready     in   1        downstream (ACS) accepts
// - bm_flat       out  4*MW     metric of symbol s={e1,e0} at [s*MW +: MW]
// - out_last      out  1        registered copy of in_last
// - out_pair_idx  out  CNT_W    index of this pair within the frame, 0-based
// BEHAVIOUR
// - Per-bit distance, where r = received soft value and e = expected bit:
//   - e=0 gives d=r; e=1 gives d=(2**SW-1)-r.
//   - An erased bit gives d=0 for both e values.
// - Metric: bm[s] = d1(e1) + d0(e0), computed unsigned at MW bits; it cannot overflow,
//   since the maximum is 2*(2**SW-1).
// - Handshake:
//   - A transfer occurs when valid && ready.
//   - in_ready = !out_valid || out_ready, i.e. the stage holds one entry and supports
//     full throughput.
//   - Latency is 1 cycle: metrics accepted at edge N appear with out_valid=1 after edge N.
//   - While out_valid && !out_ready, bm_flat, out_last and out_pair_idx hold stable.
//   - Simultaneous accept and drain in the same cycle loads the new entry; nothing is lost.
// - Pair counter pair_cnt (CNT_W):
//   - Increments on every accepted pair and is sampled into out_pair_idx.
//   - Accepting a pair with in_last=1 sets pair_cnt to 0, so the next pair gets idx 0.
//   - Counter wraps 2**CNT_W-1 -> 0 silently.
// - Output register: pure data register.
//   - States: EMPTY (out_valid=0) and FULL (out_valid=1).
//   - EMPTY -> FULL on accept. FULL -> EMPTY on drain without accept.
//   - FULL stays FULL on accept+drain or on stall.
// - Reset (rst_n=0 at an edge):
//   - out_valid=0, bm_flat=0, out_last=0, out_pair_idx=0, pair_cnt=0.
//   - in_ready is 1 in the cycle after reset.
//   - Reset mid-frame discards the held entry and restarts the index at 0.
// - in_valid=1 with an X/undefined rx_pair is not checked; data is don't-care when
//   in_valid=0.
// CONFIGURATION
// - BMC_NORM_EN defined:
//   - The registered metrics are normalised: bm[s] minus min(bm[0..3]), so at least one
//     output metric is 0.
//   - Normalisation is combinational before the register; latency is unchanged.
// - BMC_NORM_EN undefined: raw metrics are output. The port list is identical in both builds.
// TESTING (SW=3, CNT_W=16)
// - Reset: hold rst_n=0 for 2 cycles -> out_valid=0, bm_flat=0, out_pair_idx=0, in_ready=1.
// - rx c1=7,c0=0, no erase -> 1 cycle later bm{00,01,10,11} = {7,14,0,7}.
//   - Both builds give the same result (min is already 0).
// - rx c1=3,c0=4 -> raw {7,6,8,7}; with BMC_NORM_EN -> {1,0,2,1}.
// - rx c1=7,c0=7, rx_erase=2'b01 -> raw {7,7,0,0}; with BMC_NORM_EN unchanged.
// - Back-pressure: stream 5 pairs while out_ready is held 0 for 3 cycles mid-stream.
//   - Outputs are held stable while stalled, in_ready=0 during the stall.
//   - All 5 pairs are delivered in order with idx 0..4.
// - Frame: stream 3 pairs, the 3rd with in_last=1, then 2 more pairs.
//   - Indices are 0,1,2 (out_last=1 on idx 2), then 0,1.
//   - Asserting rst_n=0 mid-stream drops the held entry; the next accepted pair has idx 0.

Source files
------------

// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric unit (rate-1/2, K=3) with a one-entry valid/ready output stage.
// Optional build macro BMC_NORM_EN: subtract the minimum metric before registering.
module bmc_soft_pipe #(
  parameter int SW    = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*SW-1:0]         rx_pair,
  input  logic [1:0]              rx_erase,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*(SW+1)-1:0]     bm_flat,
  output logic                    out_last,
  output logic [CNT_W-1:0]        out_pair_idx
);

  localparam int MW = SW + 1;

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              drain_s;
  logic [CNT_W-1:0]  pair_cnt_r;
  logic [MW-1:0]     d1_e0_s, d1_e1_s, d0_e0_s, d0_e1_s;
  logic [MW-1:0]     raw_s [4];
  logic [MW-1:0]     nrm_s [4];
  logic [4*MW-1:0]   bm_nxt_s;
`ifdef BMC_NORM_EN
  logic [MW-1:0]     min_s;
`endif

  // Distance of one soft bit to an expected bit; (2**SW-1)-r is the bitwise inverse of r.
  function automatic logic [MW-1:0] bit_dist(input logic [SW-1:0] r, input logic e,
                                             input logic erase);
    logic [MW-1:0] d;
    if (erase) begin
      d = {MW{1'b0}};
    end else if (e) begin
      d = {1'b0, ~r};
    end else begin
      d = {1'b0, r};
    end
    return d;
  endfunction

  assign out_valid = (state_r == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = out_valid && out_ready;

  // Branch metrics for all four expected symbols, optionally normalised.
  always_comb begin
    d1_e0_s = bit_dist(rx_pair[2*SW-1:SW], 1'b0, rx_erase[1]);
    d1_e1_s = bit_dist(rx_pair[2*SW-1:SW], 1'b1, rx_erase[1]);
    d0_e0_s = bit_dist(rx_pair[SW-1:0],    1'b0, rx_erase[0]);
    d0_e1_s = bit_dist(rx_pair[SW-1:0],    1'b1, rx_erase[0]);
    raw_s[0] = d1_e0_s + d0_e0_s;
    raw_s[1] = d1_e0_s + d0_e1_s;
    raw_s[2] = d1_e1_s + d0_e0_s;
    raw_s[3] = d1_e1_s + d0_e1_s;
`ifdef BMC_NORM_EN
    min_s = raw_s[0];
    for (int s = 1; s < 4; s++) begin
      if (raw_s[s] < min_s) begin
        min_s = raw_s[s];
      end else begin
        min_s = min_s;
      end
    end
    for (int s = 0; s < 4; s++) begin
      nrm_s[s] = raw_s[s] - min_s;
    end
`else
    for (int s = 0; s < 4; s++) begin
      nrm_s[s] = raw_s[s];
    end
`endif
    bm_nxt_s = {4*MW{1'b0}};
    for (int s = 0; s < 4; s++) begin
      bm_nxt_s[s*MW +: MW] = nrm_s[s];
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Occupancy next state: a simultaneous accept and drain keeps the stage full.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (drain_s && !accept_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Output data and frame index; loaded only on accept so a stall holds them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bm_flat      <= {4*MW{1'b0}};
      out_last     <= 1'b0;
      out_pair_idx <= {CNT_W{1'b0}};
      pair_cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      bm_flat      <= bm_nxt_s;
      out_last     <= in_last;
      out_pair_idx <= pair_cnt_r;
      if (in_last) begin
        pair_cnt_r <= {CNT_W{1'b0}};
      end else begin
        pair_cnt_r <= pair_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      bm_flat      <= bm_flat;
      out_last     <= out_last;
      out_pair_idx <= out_pair_idx;
      pair_cnt_r   <= pair_cnt_r;
    end
  end

endmodule
